// File: rtl/mul_pkg.sv
// Shared definitions for the mul_stage pipeline: widths and op encodings.
package mul_pkg;

    localparam int XLEN   = 64;
    localparam int TAG_W  = 4;
    localparam int PROD_W = 2 * XLEN;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_MULW   = 3'b100
    } mul_op_e;

endpackage

// File: rtl/mul_fixup.sv
// Result select for the external multiplier core, including the MULH sign correction.
// MULW is only legal when MUL_WORD_OP_EN is defined.
module mul_fixup
    import mul_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic [PROD_W-1:0] core_res,
    output logic [XLEN-1:0]   data,
    output logic              err
);

    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] hi_corr;

    always_comb begin
        hi = core_res[PROD_W-1:XLEN];
        lo = core_res[XLEN-1:0];
        // Core treats b as unsigned; a negative b contributes an extra a*2^64.
        hi_corr = hi - (((op == OP_MULH) && b[XLEN-1]) ? a : '0);

        data = '0;
        err  = 1'b0;
        case (op)
            OP_MUL:              data = lo;
            OP_MULH:             data = hi_corr;
            OP_MULHSU, OP_MULHU: data = hi;
`ifdef MUL_WORD_OP_EN
            OP_MULW:             data = {{(XLEN-32){core_res[31]}}, core_res[31:0]};
`endif
            default:             err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mul_stage.sv
// Two-stage valid/ready wrapper around an external 64x64 multiplier core.
// MUL_WORD_OP_EN enables the MULW op (handled inside mul_fixup).
module mul_stage
    import mul_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_op,
    input  logic [XLEN-1:0]     in_a,
    input  logic [XLEN-1:0]     in_b,
    input  logic [TAG_W-1:0]    in_tag,
    output logic [XLEN-1:0]     core_a,
    output logic [XLEN-1:0]     core_b,
    output logic                core_sign,
    input  logic [PROD_W-1:0]   core_res,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err
);

    logic             s1_vld_q, s1_vld_d;
    logic [2:0]       s1_op_q,  s1_op_d;
    logic [XLEN-1:0]  s1_a_q,   s1_a_d;
    logic [XLEN-1:0]  s1_b_q,   s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_vld_q,  s2_vld_d;
    logic [XLEN-1:0]  s2_data_q, s2_data_d;
    logic [TAG_W-1:0] s2_tag_q,  s2_tag_d;
    logic             s2_err_q,  s2_err_d;

    logic             s1_adv;
    logic             accept;
    logic [XLEN-1:0]  fix_data;
    logic             fix_err;

    mul_fixup u_fixup (
        .op       (s1_op_q),
        .a        (s1_a_q),
        .b        (s1_b_q),
        .core_res (core_res),
        .data     (fix_data),
        .err      (fix_err)
    );

    always_comb begin
        s1_adv   = s1_vld_q && (!s2_vld_q || out_ready);
        in_ready = !s1_vld_q || s1_adv;
        accept   = in_valid && in_ready;

        s1_vld_d = s1_vld_q;
        s1_op_d  = s1_op_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_tag_d = s1_tag_q;
        if (accept) begin
            s1_vld_d = 1'b1;
            s1_op_d  = in_op;
            s1_a_d   = in_a;
            s1_b_d   = in_b;
            s1_tag_d = in_tag;
        end else if (s1_adv) begin
            s1_vld_d = 1'b0;
        end

        // Payload only changes on a load, so it holds while stalled.
        s2_vld_d  = s2_vld_q;
        s2_data_d = s2_data_q;
        s2_tag_d  = s2_tag_q;
        s2_err_d  = s2_err_q;
        if (s1_adv) begin
            s2_vld_d  = 1'b1;
            s2_data_d = fix_data;
            s2_tag_d  = s1_tag_q;
            s2_err_d  = fix_err;
        end else if (out_ready) begin
            s2_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_op_q   <= '0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_tag_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_tag_q  <= '0;
            s2_err_q  <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_op_q   <= s1_op_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_tag_q  <= s1_tag_d;
            s2_vld_q  <= s2_vld_d;
            s2_data_q <= s2_data_d;
            s2_tag_q  <= s2_tag_d;
            s2_err_q  <= s2_err_d;
        end
    end

    assign core_a    = s1_a_q;
    assign core_b    = s1_b_q;
    assign core_sign = (s1_op_q == OP_MULH) || (s1_op_q == OP_MULHSU);

    assign out_valid = s2_vld_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;
    assign out_err   = s2_err_q;

endmodule

// File: tb/tb_mul_stage.sv
// Randomized self-checking bench for mul_stage; the multiplier core is modelled here.
module tb_mul_stage;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic [63:0]   in_a = '0;
    logic [63:0]   in_b = '0;
    logic [3:0]    in_tag = '0;
    logic [63:0]   core_a;
    logic [63:0]   core_b;
    logic          core_sign;
    logic [127:0]  core_res;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_data;
    logic [3:0]    out_tag;
    logic          out_err;

    mul_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .core_a    (core_a),
        .core_b    (core_b),
        .core_sign (core_sign),
        .core_res  (core_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    // Core: a optionally sign-extended, b always zero-extended.
    assign core_res = (core_sign ? {{64{core_a[63]}}, core_a} : {64'b0, core_a}) * {64'b0, core_b};

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  tag;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    int          last_lat = -1;
    logic        hold_pend = 1'b0;
    logic [68:0] hold_val = '0;

    task automatic chk(input string name, input logic [68:0] obs, input logic [68:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    // Reference: full-width products computed arithmetically from the op semantics.
    function automatic logic [64:0] ref_res(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] sa, sb_, za, zb, p;
        sa = {{64{a[63]}}, a};
        sb_ = {{64{b[63]}}, b};
        za = {64'b0, a};
        zb = {64'b0, b};
        case (op)
            3'b000: begin p = za * zb;  return {1'b0, p[63:0]};   end
            3'b001: begin p = sa * sb_; return {1'b0, p[127:64]}; end
            3'b010: begin p = sa * zb;  return {1'b0, p[127:64]}; end
            3'b011: begin p = za * zb;  return {1'b0, p[127:64]}; end
`ifdef MUL_WORD_OP_EN
            3'b100: begin p = za * zb;  return {1'b0, {32{p[31]}}, p[31:0]}; end
`endif
            default: return {1'b1, 64'b0};
        endcase
    endfunction

    task automatic cyc(input logic v, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] tag, input logic ordy, output logic acc);
        logic [64:0] r;
        exp_t e;
        @(negedge clk);
        in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = ordy;
        #1;
        if (hold_pend) begin
            chk("hold_valid", {68'b0, out_valid}, 69'd1);
            chk("hold_stable", {out_err, out_tag, out_data}, hold_val);
        end
        hold_pend = out_valid && !ordy;
        hold_val  = {out_err, out_tag, out_data};
        acc = v && in_ready;
        if (acc) begin
            r = ref_res(op, a, b);
            e.data = r[63:0]; e.err = r[64]; e.tag = tag; e.cyc = cyc_n;
            sb.push_back(e);
        end
        if (out_valid && ordy) begin
            if (sb.size() == 0) begin
                chk("spurious_out", {68'b0, out_valid}, 69'd0);
            end else begin
                e = sb.pop_front();
                chk("out_data", {5'b0, out_data}, {5'b0, e.data});
                chk("out_tag", {65'b0, out_tag}, {65'b0, e.tag});
                chk("out_err", {68'b0, out_err}, {68'b0, e.err});
                last_lat = cyc_n - e.cyc;
            end
        end
        cyc_n++;
    endtask

    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            cyc(1'b1, op, a, b, tag, 1'b1, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 69'd0, 69'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 3'b0, 64'b0, 64'b0, 4'b0, 1'b1, acc);
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'hFFFF_FFFF_FFFF_FFFF;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return {32'b0, $urandom()};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        logic acc;
        #2;
        chk("rst_in_ready", {68'b0, in_ready}, 69'd1);
        chk("rst_out_valid", {68'b0, out_valid}, 69'd0);
        chk("rst_out_bus", {out_err, out_tag, out_data}, 69'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Basic MUL with latency
        send(3'b000, 64'd3, 64'd5, 4'd1);
        idle(3);
        chk("mul_latency", 69'(last_lat), 69'd2);

        send(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd2);
        send(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd3);
        send(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd4);
        send(3'b100, 64'h7FFF_FFFF, 64'd2, 4'd5);
        send(3'b111, 64'd7, 64'd9, 4'd6);
        send(3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'd7);
        idle(4);
        chk("directed_drain", 69'(sb.size()), 69'd0);

        // Back-to-back with output stalled for three cycles
        cyc(1'b1, 3'b000, 64'd10, 64'd10, 4'd0, 1'b0, acc);
        chk("stall_acc0", {68'b0, acc}, 69'd1);
        cyc(1'b1, 3'b000, 64'd11, 64'd11, 4'd1, 1'b0, acc);
        chk("stall_acc1", {68'b0, acc}, 69'd1);
        cyc(1'b1, 3'b000, 64'd12, 64'd12, 4'd2, 1'b0, acc);
        chk("stall_in_ready", {68'b0, in_ready}, 69'd0);
        cyc(1'b1, 3'b000, 64'd12, 64'd12, 4'd2, 1'b1, acc);
        chk("stall_acc2", {68'b0, acc}, 69'd1);
        send(3'b000, 64'd13, 64'd13, 4'd3);
        idle(4);
        chk("stall_drain", 69'(sb.size()), 69'd0);

        // Reset with two requests in flight
        cyc(1'b1, 3'b011, 64'd5, 64'd6, 4'd8, 1'b0, acc);
        cyc(1'b1, 3'b011, 64'd7, 64'd8, 4'd9, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {68'b0, out_valid}, 69'd0);
        chk("midrst_in_ready", {68'b0, in_ready}, 69'd1);
        chk("midrst_out_bus", {out_err, out_tag, out_data}, 69'd0);
        sb.delete();
        hold_pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 3'b000, 64'd2, 64'd21, 4'd10, 1'b1, acc);
        chk("acc_after_rst", {68'b0, acc}, 69'd1);
        idle(4);
        chk("rst_drain", 69'(sb.size()), 69'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rnd64(), rnd64(),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 7), acc);
        end
        idle(20);
        chk("final_drain", 69'(sb.size()), 69'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
